// File: rtl/axis_mux_arb_if.sv
// Bundle of the AXI-Stream signals around the packet mux: NUM_CH slave lanes in, one master lane out.
// Latency: none, wires only.
// Backpressure: S_TREADY flows upstream, M_TREADY flows in from downstream.
//
// Ports / signals:
//   S_TDATA  [NUM_CH*DATA_WIDTH]  channel i data at [i*DATA_WIDTH +: DATA_WIDTH]
//   S_TVALID / S_TLAST / S_TREADY [NUM_CH]  one bit per channel
//   M_TDATA [DATA_WIDTH], M_TVALID, M_TLAST, M_TREADY, M_TID [CW]
// Modports:
//   slave  - the mux itself: consumes the S lanes, produces the M lane
//   master - the surrounding environment: produces the S lanes, consumes the M lane
interface axis_mux_arb_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CH     = 4,
  parameter int CW         = ($clog2(NUM_CH) > 1) ? $clog2(NUM_CH) : 1
);
  logic [NUM_CH*DATA_WIDTH-1:0] S_TDATA;
  logic [NUM_CH-1:0]            S_TVALID;
  logic [NUM_CH-1:0]            S_TLAST;
  logic [NUM_CH-1:0]            S_TREADY;

  logic [DATA_WIDTH-1:0]        M_TDATA;
  logic                         M_TVALID;
  logic                         M_TLAST;
  logic                         M_TREADY;
  logic [CW-1:0]                M_TID;

  modport slave (
    input  S_TDATA, S_TVALID, S_TLAST, M_TREADY,
    output S_TREADY, M_TDATA, M_TVALID, M_TLAST, M_TID
  );

  modport master (
    output S_TDATA, S_TVALID, S_TLAST, M_TREADY,
    input  S_TREADY, M_TDATA, M_TVALID, M_TLAST, M_TID
  );
endinterface

// File: rtl/axis_mux_arb.sv
// Packet-locked AXI-Stream N:1 mux; channel picked by sel (MODE=0) or round-robin (MODE=1).
// Latency: 1 arbitration cycle per packet, then 1 registered cycle per beat; 1 beat/cycle inside a packet.
// Backpressure: S_TREADY of the granted channel is (!M_TVALID || M_TREADY); output beat held while stalled.
//
// Ports:
//   ACLK      sole clock, rising edge
//   ARESET    synchronous active-high reset
//   sel       requested channel, only looked at in MODE=0 while idle
//   bus       axis_mux_arb_if.slave: S_* lanes in, M_* lane out, M_TID = source channel of the beat
//   PKT_CNT   16-bit wrapping count of TLAST beats handed off on the M side
module axis_mux_arb #(
  parameter  int DATA_WIDTH = 8,
  parameter  int NUM_CH     = 4,
  parameter  int MODE       = 0,
  localparam int CW         = ($clog2(NUM_CH) > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic          ACLK,
  input  logic          ARESET,
  input  logic [CW-1:0] sel,
  axis_mux_arb_if.slave bus,
  output logic [15:0]   PKT_CNT
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // FSM and arbitration state
  state_t                r_state;
  state_t                w_state_nxt;
  logic [CW-1:0]         r_grant;
  logic [CW-1:0]         w_grant_nxt;
  logic [CW-1:0]         r_last_grant;
  logic [CW-1:0]         w_last_grant_nxt;

  // output register stage
  logic [DATA_WIDTH-1:0] r_m_tdata;
  logic                  r_m_tvalid;
  logic                  r_m_tlast;
  logic [CW-1:0]         r_m_tid;
  logic [15:0]           r_pkt_cnt;

  // combinational helpers
  logic                  w_out_free;
  logic                  w_accept;
  logic                  w_m_hs;
  logic                  w_req_vld;
  logic [CW-1:0]         w_req_ch;
  logic                  w_sel_vld;
  logic                  w_sel_last;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic [NUM_CH-1:0]     w_s_tready;

  // The output register can take a beat when empty or when its beat leaves this cycle.
  assign w_out_free = !r_m_tvalid || bus.M_TREADY;
  assign w_m_hs     = r_m_tvalid && bus.M_TREADY;
  assign w_accept   = (r_state == LOCKED) && w_sel_vld && w_out_free;

  // Mux the currently granted channel.
  always_comb begin
    w_sel_vld  = 1'b0;
    w_sel_last = 1'b0;
    w_sel_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (r_grant == CW'(i)) begin
        w_sel_vld  = bus.S_TVALID[i];
        w_sel_last = bus.S_TLAST[i];
        w_sel_data = bus.S_TDATA[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Request picking, only consumed in IDLE.
  // Round-robin walks last_grant+1, +2, ... wrapping; the loop runs from the far end
  // toward the near end so the closest valid channel is the last (winning) write.
  // A sel value beyond NUM_CH-1 simply never matches a channel.
  always_comb begin
    w_req_vld = 1'b0;
    w_req_ch  = r_grant;
    if (MODE == 0) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if ((sel == CW'(i)) && bus.S_TVALID[i]) begin
          w_req_vld = 1'b1;
          w_req_ch  = CW'(i);
        end
      end
    end else begin
      for (int k = NUM_CH; k >= 1; k--) begin
        for (int i = 0; i < NUM_CH; i++) begin
          if ((i == ((int'(r_last_grant) + k) % NUM_CH)) && bus.S_TVALID[i]) begin
            w_req_vld = 1'b1;
            w_req_ch  = CW'(i);
          end
        end
      end
    end
  end

  // Next-state logic. The lock is only ever released by an accepted TLAST beat.
  always_comb begin
    w_state_nxt      = r_state;
    w_grant_nxt      = r_grant;
    w_last_grant_nxt = r_last_grant;
    case (r_state)
      IDLE: begin
        if (w_req_vld) begin
          w_state_nxt = LOCKED;
          w_grant_nxt = w_req_ch;
          if (MODE != 0) begin
            w_last_grant_nxt = w_req_ch;
          end
        end
      end
      LOCKED: begin
        if (w_accept && w_sel_last) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Only the granted channel sees ready, and only while locked; IDLE is the arbitration bubble.
  always_comb begin
    w_s_tready = '0;
    if (r_state == LOCKED) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (r_grant == CW'(i)) begin
          w_s_tready[i] = w_out_free;
        end
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state      <= IDLE;
      r_grant      <= '0;
      // Channel 0 gets first round-robin priority out of reset.
      r_last_grant <= CW'(NUM_CH - 1);
    end else begin
      r_state      <= w_state_nxt;
      r_grant      <= w_grant_nxt;
      r_last_grant <= w_last_grant_nxt;
    end
  end

  // Output register: load on accept, otherwise drain on handshake; data/last/id hold when drained.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_m_tvalid <= 1'b0;
      r_m_tlast  <= 1'b0;
      r_m_tdata  <= '0;
      r_m_tid    <= '0;
    end else if (w_accept) begin
      r_m_tvalid <= 1'b1;
      r_m_tlast  <= w_sel_last;
      r_m_tdata  <= w_sel_data;
      r_m_tid    <= r_grant;
    end else if (w_m_hs) begin
      r_m_tvalid <= 1'b0;
    end
  end

  // Completed-packet counter, free-running wrap at 16 bits.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_pkt_cnt <= '0;
    end else if (w_m_hs && r_m_tlast) begin
      r_pkt_cnt <= r_pkt_cnt + 16'd1;
    end
  end

  assign bus.S_TREADY = w_s_tready;
  assign bus.M_TDATA  = r_m_tdata;
  assign bus.M_TVALID = r_m_tvalid;
  assign bus.M_TLAST  = r_m_tlast;
  assign bus.M_TID    = r_m_tid;
  assign PKT_CNT      = r_pkt_cnt;

endmodule
